// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register: owns pcF, issues one-outstanding fetches over a
// valid/ready instruction-memory port, and applies decode redirects plus stall/flush control.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pcsrcD,
  input  logic [31:0] pcbranchD,
  input  logic        jumpD,
  input  logic [31:0] pcjumpD,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pcF,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D,
  output logic        validD
);

  typedef enum logic [1:0] {StReq, StWait, StHold, StKill} stateT;

  stateT       stateQ, stateNext;
  logic [31:0] pcNext, holdBuf, holdNext, loadData, target, pcPlus4;
  logic        loadId, redirect, reqFire;

  assign pcPlus4        = pcF + 32'd4;
  assign redirect       = (pcsrcD | jumpD) & validD & ~stallD;
  assign target         = (jumpD ? pcjumpD : pcbranchD) & 32'hFFFF_FFFC;
  assign imem_req_valid = reset & (stateQ == StReq);
  assign imem_addr      = pcF;
  assign reqFire        = imem_req_valid & imem_req_ready;

  always_comb begin
    stateNext = stateQ;
    pcNext    = pcF;
    holdNext  = holdBuf;
    loadId    = 1'b0;
    loadData  = imem_rsp_data;
    unique case (stateQ)
      StReq: begin
        if (redirect) begin
          pcNext = target;
          // Request already accepted for the old PC: its response must be discarded.
          if (reqFire) stateNext = StKill;
        end else if (reqFire) begin
          stateNext = StWait;
        end
      end
      StWait: begin
        if (imem_rsp_valid) begin
          if (redirect) begin
            pcNext    = target;
            stateNext = StReq;
          end else if (stallD) begin
            holdNext  = imem_rsp_data;
            stateNext = StHold;
          end else begin
            loadId    = 1'b1;
            pcNext    = pcPlus4;
            stateNext = StReq;
          end
        end else if (redirect) begin
          pcNext    = target;
          stateNext = StKill;
        end
      end
      StHold: begin
        if (redirect) begin
          pcNext    = target;
          stateNext = StReq;
        end else if (!stallD) begin
          loadId    = 1'b1;
          loadData  = holdBuf;
          pcNext    = pcPlus4;
          stateNext = StReq;
        end
      end
      StKill: begin
        if (redirect) pcNext = target;
        if (imem_rsp_valid) stateNext = StReq;
      end
      default: stateNext = StReq;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ  <= StReq;
      pcF     <= RESET_PC;
      holdBuf <= '0;
    end else begin
      stateQ  <= stateNext;
      pcF     <= pcNext;
      holdBuf <= holdNext;
    end
  end

  // Stall holds ID; otherwise ID takes the fetched word only when neither flushed nor redirected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instrD   <= NOP;
      pcplus4D <= '0;
      validD   <= 1'b0;
    end else if (!stallD) begin
      if (loadId && !flushD) begin
        instrD   <= loadData;
        pcplus4D <= pcPlus4;
        validD   <= 1'b1;
      end else begin
        instrD   <= NOP;
        pcplus4D <= '0;
        validD   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised scoreboard bench for fetch_stage: a transaction-level model of the fetch stream
// predicts ID contents and pcF for every clock edge; a monitor compares them after each edge.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallD, flushD, pcsrcD, jumpD;
  logic [31:0] pcbranchD, pcjumpD;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] pcF, instrD, pcplus4D;
  logic        validD;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
    .clk           (clk),
    .reset         (reset),
    .stallD        (stallD),
    .flushD        (flushD),
    .pcsrcD        (pcsrcD),
    .pcbranchD     (pcbranchD),
    .jumpD         (jumpD),
    .pcjumpD       (pcjumpD),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .pcF           (pcF),
    .instrD        (instrD),
    .pcplus4D      (pcplus4D),
    .validD        (validD)
  );

  always #5 clk = ~clk;

  int edgeCnt = 0;
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  typedef struct {
    int          cyc;
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] pc;
  } expT;
  expT expQ[$];

  int nChecks = 0;
  int nFail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  function automatic logic [31:0] pickTarget();
    case ($urandom_range(4))
      0:       return 32'hFFFF_FFFE;
      1:       return 32'h0000_0040;
      2:       return 32'hFFFF_FFF8;
      default: return $urandom();
    endcase
  endfunction

  // Reference model: fetch PC, the one outstanding memory request, a parked instruction, ID.
  logic [31:0] mPc, mOutAddr, mHeldAddr, mHeldData, mInstr, mPc4;
  bit          mOut, mOutStale, mHeld, mValid;
  int          mOutLat;
  int          stallPct, redirPct, flushPct, readyPct, maxLat;

  task automatic resetModel();
    mPc = RESET_PC; mOut = 0; mOutStale = 0; mOutLat = 0; mHeld = 0;
    mValid = 0; mInstr = NOP; mPc4 = '0;
  endtask

  task automatic quietInputs();
    stallD = 0; flushD = 0; pcsrcD = 0; jumpD = 0; pcbranchD = '0; pcjumpD = '0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
  endtask

  task automatic pushExp();
    expT e;
    e.cyc = edgeCnt + 1; e.v = mValid; e.instr = mInstr; e.pc4 = mPc4; e.pc = mPc;
    expQ.push_back(e);
  endtask

  // Called just after a rising edge: drive inputs for the next edge and predict its result.
  task automatic step();
    bit          arr, reqExp, reqFire, redirect, haveItem;
    logic [31:0] tgt, itAddr, itData, oldPc;
    oldPc          = mPc;
    arr            = mOut && (mOutLat == 0);
    imem_rsp_valid = arr;
    imem_rsp_data  = arr ? memWord(mOutAddr) : $urandom();
    imem_req_ready = ($urandom_range(99) < readyPct);
    stallD         = ($urandom_range(99) < stallPct);
    flushD         = ($urandom_range(99) < flushPct);
    pcsrcD         = ($urandom_range(99) < redirPct);
    jumpD          = ($urandom_range(99) < redirPct);
    pcbranchD      = pickTarget();
    pcjumpD        = pickTarget();

    reqExp = !mOut && !mHeld;
    check("imem_req_valid", {31'b0, imem_req_valid}, {31'b0, reqExp});
    if (reqExp && imem_req_valid) check("imem_addr", imem_addr, mPc);
    reqFire  = reqExp && imem_req_ready;
    redirect = (pcsrcD || jumpD) && mValid && !stallD;
    tgt      = (jumpD ? pcjumpD : pcbranchD) & 32'hFFFF_FFFC;

    haveItem = 0; itAddr = '0; itData = '0;
    if (mHeld) begin
      haveItem = 1; itAddr = mHeldAddr; itData = mHeldData;
    end else if (arr && !mOutStale) begin
      haveItem = 1; itAddr = mOutAddr; itData = memWord(mOutAddr);
    end
    if (arr) mOut = 0;
    else if (mOut) mOutLat--;

    if (redirect) begin
      mHeld = 0;
      if (mOut) mOutStale = 1;
      mPc = tgt; mValid = 0; mInstr = NOP;
    end else if (stallD) begin
      if (haveItem) begin
        mHeld = 1; mHeldAddr = itAddr; mHeldData = itData;
      end
    end else begin
      mHeld = 0;
      if (haveItem) mPc = itAddr + 32'd4;
      if (haveItem && !flushD) begin
        mValid = 1; mInstr = itData; mPc4 = itAddr + 32'd4;
      end else begin
        mValid = 0; mInstr = NOP;
      end
    end

    if (reqFire) begin
      mOut = 1; mOutAddr = oldPc; mOutStale = redirect; mOutLat = $urandom_range(maxLat);
    end
    pushExp();
  endtask

  task automatic checkInReset(input string tag);
    check({tag, " pcF"}, pcF, RESET_PC);
    check({tag, " validD"}, {31'b0, validD}, 32'd0);
    check({tag, " instrD"}, instrD, NOP);
    check({tag, " pcplus4D"}, pcplus4D, 32'd0);
    check({tag, " imem_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
  endtask

  // Caller sits just after a rising edge with reset asserted.
  task automatic releaseReset();
    reset = 1;
    quietInputs();
    resetModel();
    pushExp();
    #1;
    check("req after reset", {31'b0, imem_req_valid}, 32'd1);
    check("addr after reset", imem_addr, RESET_PC);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      step();
    end
  endtask

  // Monitor: compares each edge's prediction once that edge has happened.
  initial begin
    expT e;
    forever begin
      @(posedge clk); #3;
      while (expQ.size() > 0 && expQ[0].cyc <= edgeCnt) begin
        e = expQ.pop_front();
        check("validD", {31'b0, validD}, {31'b0, e.v});
        check("instrD", instrD, e.instr);
        if (e.v) check("pcplus4D", pcplus4D, e.pc4);
        check("pcF", pcF, e.pc);
      end
    end
  end

  initial begin
    int guard;
    reset = 0;
    quietInputs();
    resetModel();
    #2 checkInReset("reset");
    repeat (2) @(posedge clk);
    #1 releaseReset();

    // Zero-wait memory, no hazards: one instruction every two cycles.
    stallPct = 0; redirPct = 0; flushPct = 0; readyPct = 100; maxLat = 0;
    runCycles(30);
    // Slow, back-pressured memory.
    readyPct = 60; maxLat = 3;
    runCycles(200);
    // Stalls while responses arrive.
    stallPct = 30;
    runCycles(300);
    // Everything: redirects (jump and branch together), flushes, wrap-around targets.
    redirPct = 15; flushPct = 10;
    runCycles(2500);

    // Asynchronous reset while a live request is outstanding.
    guard = 0;
    while (!(mOut && !mOutStale) && guard < 100) begin
      runCycles(1);
      guard++;
    end
    check("found outstanding request", {31'b0, mOut && !mOutStale}, 32'd1);
    @(posedge clk); #1;
    reset = 0;
    imem_rsp_valid = 0;
    expQ.delete();
    #1 checkInReset("mid-wait reset");
    repeat (2) @(posedge clk);
    #1 releaseReset();
    runCycles(1500);

    quietInputs();
    @(posedge clk); #5;
    check("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
